// File: rtl/dq_serdes.sv
// DQ-side SerDes endpoint: serializes FIFO-buffered write bursts onto DQ and
// assembles read beats into a parallel word under the scheduler's beat strobe.
module dq_serdes #(
  parameter int DQ_W     = 8,
  parameter int BL       = 2,
  parameter int WF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SerDes_en,
  input  logic                 SerDes_sel,
  input  logic [BL*DQ_W-1:0]   wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DQ_W-1:0]      dq_out,
  output logic                 dq_oe,
  input  logic [DQ_W-1:0]      dq_in,
  output logic [BL*DQ_W-1:0]   rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 underrun,
  output logic                 overrun,
  output logic                 partial
);

  localparam int BW = BL * DQ_W;
  localparam int CW = (BL > 1) ? $clog2(BL) : 1;
  localparam int AW = (WF_DEPTH > 1) ? $clog2(WF_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(BL - 1);

  logic [BW-1:0]   r_mem [WF_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic [CW-1:0]   r_bcnt;
  logic            r_dir, r_nodata;
  logic [BW-1:0]   r_shift;
  logic [DQ_W-1:0] r_dq_out;
  logic            r_dq_oe;
  logic [BW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_underrun, r_overrun, r_partial;

  logic            w_empty, w_full, w_abort, w_start, w_last;
  logic            w_wbeat, w_rbeat, w_nodata, w_push, w_pop;
  logic [CW-1:0]   w_cnt;
  logic [BW-1:0]   w_head, w_asm;
  logic [DQ_W-1:0] w_beat;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = wr_valid && !w_full;

  // An aborted burst restarts at beat 0, so the current beat (if any) is a fresh start.
  assign w_abort = (r_bcnt != '0) && (!SerDes_en || (SerDes_sel != r_dir));
  assign w_cnt   = w_abort ? '0 : r_bcnt;
  assign w_start = SerDes_en && (w_cnt == '0);
  assign w_last  = (w_cnt == LAST);
  assign w_wbeat = SerDes_en && SerDes_sel;
  assign w_rbeat = SerDes_en && !SerDes_sel;

  // Emptiness is judged once per burst; a burst that starts empty stays zero-filled.
  assign w_nodata = (w_cnt == '0) ? w_empty : r_nodata;
  assign w_head   = r_mem[r_rptr[AW-1:0]];
  assign w_beat   = w_nodata ? '0 : w_head[int'(w_cnt)*DQ_W +: DQ_W];
  assign w_pop    = w_wbeat && w_last && !w_nodata;

  always_comb begin
    w_asm = r_shift;
    w_asm[int'(w_cnt)*DQ_W +: DQ_W] = dq_in;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
    if (w_rbeat) r_shift <= w_asm;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_bcnt     <= '0;
      r_dir      <= 1'b0;
      r_nodata   <= 1'b0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
      r_partial  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_abort) r_partial <= 1'b1;

      if (SerDes_en) r_bcnt <= w_last ? '0 : w_cnt + 1'b1;
      else           r_bcnt <= '0;
      if (w_start) r_dir <= SerDes_sel;

      if (w_wbeat) begin
        r_dq_out <= w_beat;
        r_dq_oe  <= 1'b1;
        if (w_cnt == '0) r_nodata <= w_empty;
        if (w_start && w_empty) r_underrun <= 1'b1;
      end else begin
        r_dq_oe <= 1'b0;
      end

      // A completing burst wins over the consumer's acceptance of the old word.
      if (w_rbeat && w_last) begin
        r_rd_data  <= w_asm;
        r_rd_valid <= 1'b1;
        if (r_rd_valid && !rd_ready) r_overrun <= 1'b1;
      end else if (r_rd_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign wr_ready = !w_full;
  assign dq_out   = r_dq_out;
  assign dq_oe    = r_dq_oe;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign underrun = r_underrun;
  assign overrun  = r_overrun;
  assign partial  = r_partial;

endmodule

// File: tb/tb_dq_serdes.sv
// Scoreboard bench for dq_serdes: a queue-based burst model predicts DQ beats
// and read words; a negedge monitor pops and compares what the DUT presents.
module tb_dq_serdes;

  localparam int DQ_W = 8;
  localparam int BL   = 2;
  localparam int WF   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, sel = 1'b0, wv = 1'b0, rr = 1'b1;
  logic [15:0] wd = '0;
  logic [7:0]  dqi = '0;
  logic        wr_ready, dq_oe, rd_valid, underrun, overrun, partial;
  logic [7:0]  dq_out;
  logic [15:0] rd_data;

  dq_serdes #(.DQ_W(DQ_W), .BL(BL), .WF_DEPTH(WF)) dut (
    .clk(clk), .rst(rst), .SerDes_en(en), .SerDes_sel(sel),
    .wr_data(wd), .wr_valid(wv), .wr_ready(wr_ready),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dqi),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rr),
    .underrun(underrun), .overrun(overrun), .partial(partial)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit [15:0] mq[$];
  bit [7:0]  exp_beats[$];
  bit [15:0] exp_rd[$];
  int        mcnt;
  bit        mdir, mnodata, mvalid, mdoe, mund, movr, mpart;
  bit [15:0] mshift, mword;
  bit [7:0]  mdq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete(); exp_beats.delete(); exp_rd.delete();
    mcnt = 0; mdir = 0; mnodata = 0; mvalid = 0; mdoe = 0;
    mund = 0; movr = 0; mpart = 0; mshift = '0; mword = '0; mdq = '0;
  endtask

  task automatic check_state();
    chk("wr_ready", wr_ready, (mq.size() < WF));
    chk("dq_oe", dq_oe, mdoe);
    chk("dq_out", dq_out, mdq);
    chk("rd_valid", rd_valid, mvalid);
    chk("rd_data", rd_data, mword);
    chk("underrun", underrun, mund);
    chk("overrun", overrun, movr);
    chk("partial", partial, mpart);
  endtask

  // One scheduler cycle as described by the burst rules, in model terms.
  task automatic model(input bit e, input bit s, input bit [7:0] d,
                       input bit v, input bit [15:0] w, input bit r);
    bit        full;
    bit        done;
    int        c;
    bit [15:0] head;
    bit [7:0]  beat;
    full = (mq.size() >= WF);
    done = 0;
    if (mcnt != 0 && (!e || s != mdir)) begin
      mpart = 1;
      mcnt = 0;
    end
    c = mcnt;
    mdoe = 0;
    if (e) begin
      if (c == 0) begin
        mdir = s;
        if (s) begin
          mnodata = (mq.size() == 0);
          if (mnodata) mund = 1;
        end
      end
      if (s) begin
        if (mnodata) beat = '0;
        else begin
          head = mq[0];
          beat = head[c*8 +: 8];
        end
        exp_beats.push_back(beat);
        mdq = beat;
        mdoe = 1;
        if (c == BL-1 && !mnodata) void'(mq.pop_front());
      end else begin
        mshift[c*8 +: 8] = d;
        if (c == BL-1) begin
          done = 1;
          if (mvalid && !r) begin
            movr = 1;
            void'(exp_rd.pop_back());
          end
          mvalid = 1;
          mword = mshift;
          exp_rd.push_back(mshift);
        end
      end
      mcnt = (c == BL-1) ? 0 : c + 1;
    end
    if (!done && mvalid && r) mvalid = 0;
    if (v && !full) mq.push_back(w);
  endtask

  task automatic step(input bit e, input bit s, input bit [7:0] d,
                      input bit v, input bit [15:0] w, input bit r);
    @(posedge clk);
    #1;
    check_state();
    en = e; sel = s; dqi = d; wv = v; wd = w; rr = r;
    model(e, s, d, v, w, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 16'h0, r);
  endtask

  // Monitor: consumes whatever the DUT presents on the DQ side and read port.
  always @(negedge clk) begin
    if (rst) begin
      if (dq_oe) begin
        if (exp_beats.size() == 0) chk("dq_beat_unexpected", dq_out, 32'hFFFF_FFFF);
        else chk("dq_beat", dq_out, exp_beats.pop_front());
      end
      if (rd_valid && rr) begin
        if (exp_rd.size() == 0) chk("rd_word_unexpected", rd_data, 32'hFFFF_FFFF);
        else chk("rd_word", rd_data, exp_rd.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_ready", wr_ready, 1);
    @(negedge clk);
    rst = 1'b1;

    // Single write burst
    step(0, 0, 8'h00, 1, 16'hB2A1, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    idle(3, 1);
    chk("wr_ready_after_pop", wr_ready, 1);

    // Single read burst
    step(1, 0, 8'h3C, 0, 16'h0, 1);
    step(1, 0, 8'h5D, 0, 16'h0, 1);
    idle(3, 1);

    // Fill FIFO, attempt a third push, drain with back-to-back bursts
    step(0, 0, 8'h00, 1, 16'h1111, 1);
    step(0, 0, 8'h00, 1, 16'h2222, 1);
    step(0, 0, 8'h00, 1, 16'h3333, 1);
    chk("wr_ready_full", wr_ready, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h00, 0, 16'h0, 1);
    idle(3, 1);

    // Write burst from an empty FIFO
    step(1, 1, 8'h00, 0, 16'h0, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    idle(2, 1);
    chk("underrun_set", underrun, 1);

    // Overrun: two completions without acceptance
    step(1, 0, 8'hAA, 0, 16'h0, 0);
    step(1, 0, 8'hAA, 0, 16'h0, 0);
    step(0, 0, 8'h00, 0, 16'h0, 0);
    step(1, 0, 8'h55, 0, 16'h0, 0);
    step(1, 0, 8'h55, 0, 16'h0, 0);
    step(0, 0, 8'h00, 0, 16'h0, 0);
    chk("overrun_data", rd_data, 16'h5555);
    chk("overrun_set", overrun, 1);
    idle(3, 1);

    // Aborted write keeps the head, then full resend
    step(0, 0, 8'h00, 1, 16'hC3D4, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    step(0, 0, 8'h00, 0, 16'h0, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    step(1, 1, 8'h00, 0, 16'h0, 1);
    idle(2, 1);
    chk("partial_set", partial, 1);

    // Asynchronous reset in the middle of a read burst
    step(1, 0, 8'h77, 1, 16'h9999, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_dq_out", dq_out, 0);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_flags", {underrun, overrun, partial}, 0);
    chk("rst_wr_ready", wr_ready, 1);
    mreset();
    en = 0; sel = 0; wv = 0; rr = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2, 1);

    // Randomized traffic
    begin
      bit cs;
      cs = 0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 5) == 0) cs = ~cs;
        step(($urandom_range(0, 9) != 0), cs, 8'($urandom),
             $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 3) != 0);
      end
    end
    idle(6, 1);

    chk("beats_drained", exp_beats.size(), 0);
    chk("words_drained", exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
